uart_tx_scheduler: RTL and testbench

- Shares one byte-wide UART transmitter between NUM_REQ flit sources in interdevice_controller/uart.
- Each source offers a whole flit.
- The scheduler grants one source by round-robin, latches its flit, and streams it byte-by-byte to uart_tx over a valid/ready handshake.
- A grant holds for the entire flit, so bytes of different flits never interleave on the wire.

---
 rtl/uart_tx_scheduler_pkg.sv | 14 +
 rtl/uart_tx_scheduler_rr_arbiter.sv | 31 +++
 rtl/uart_tx_scheduler.sv | 103 ++++++++++
 tb/tb_uart_tx_scheduler.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared types for the UART flit transmit scheduler: flit/byte containers and FSM state.
package uart_tx_scheduler_pkg;

   localparam int FLIT_WIDTH = 64;

   typedef logic [FLIT_WIDTH-1:0] flit_t;
   typedef logic [7:0]            uart_byte_t;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } sched_state_e;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request after rr_ptr_i, wrapping at NUM_REQ.
module uart_tx_scheduler_rr_arbiter #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
   output logic [NUM_REQ-1:0]         grant_o,
   output logic [$clog2(NUM_REQ)-1:0] idx_o
);

   localparam int IDW = $clog2(NUM_REQ);

   int   cand;
   logic found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = (int'(rr_ptr_i) + k) % NUM_REQ;
         if (!found && req_i[IDW'(cand)]) begin
            found                = 1'b1;
            grant_o[IDW'(cand)]  = 1'b1;
            idx_o                = IDW'(cand);
         end
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Grants one flit source round-robin and streams its latched flit MSB byte first to uart_tx.
module uart_tx_scheduler #(
   parameter int NUM_REQ    = 2,
   parameter int FLIT_WIDTH = uart_tx_scheduler_pkg::FLIT_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*FLIT_WIDTH-1:0]   req_flit,
   output logic [NUM_REQ-1:0]              req_ready,
   output uart_tx_scheduler_pkg::uart_byte_t tx_data,
   output logic                            tx_valid,
   input  logic                            tx_ready,
   output logic                            busy,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id
);

   import uart_tx_scheduler_pkg::*;

   localparam int FLIT_BYTES = FLIT_WIDTH / 8;
   localparam int IDW        = $clog2(NUM_REQ);
   localparam int BW         = (FLIT_BYTES > 1) ? $clog2(FLIT_BYTES) : 1;

   sched_state_e            state_q, state_d;
   logic [FLIT_WIDTH-1:0]   shreg_q, shreg_d;
   uart_byte_t              data_q, data_d;
   logic [BW-1:0]           idx_q, idx_d;
   logic [IDW-1:0]          grant_q, grant_d;
   logic [IDW-1:0]          ptr_q, ptr_d;

   logic [NUM_REQ-1:0]      arb_oh;
   logic [IDW-1:0]          arb_idx;
   logic [FLIT_WIDTH-1:0]   win_flit;

   uart_tx_scheduler_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_i    (req_valid),
      .rr_ptr_i (ptr_q),
      .grant_o  (arb_oh),
      .idx_o    (arb_idx)
   );

   assign win_flit = req_flit[int'(arb_idx)*FLIT_WIDTH +: FLIT_WIDTH];

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      data_d    = data_q;
      idx_d     = idx_q;
      grant_d   = grant_q;
      ptr_d     = ptr_q;
      req_ready = '0;
      case (state_q)
         IDLE: begin
            req_ready = arb_oh;
            if (|arb_oh) begin
               // First byte is loaded straight away so tx_data is valid the cycle after the grant.
               data_d  = win_flit[FLIT_WIDTH-1 -: 8];
               shreg_d = win_flit << 8;
               idx_d   = '0;
               grant_d = arb_idx;
               ptr_d   = arb_idx;
               state_d = SEND;
            end
         end
         SEND: begin
            if (tx_ready) begin
               if (idx_q == BW'(FLIT_BYTES - 1)) begin
                  state_d = IDLE;
               end else begin
                  data_d  = shreg_q[FLIT_WIDTH-1 -: 8];
                  shreg_d = shreg_q << 8;
                  idx_d   = idx_q + BW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         data_q  <= '0;
         idx_q   <= '0;
         grant_q <= '0;
         ptr_q   <= IDW'(NUM_REQ - 1);
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   assign tx_valid = (state_q == SEND);
   assign busy     = (state_q == SEND);
   assign tx_data  = data_q;
   assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with two 64-bit flit sources.
module tb_uart_tx_scheduler;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   req_valid;
   logic [63:0]  flit0, flit1;
   logic [127:0] req_flit;
   logic [1:0]   req_ready;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic         busy;
   logic [0:0]   grant_id;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [63:0] F_SINGLE = 64'h0011223344556677;
   localparam logic [63:0] F_A      = 64'hA0A1A2A3A4A5A6A7;
   localparam logic [63:0] F_B      = 64'hB0B1B2B3B4B5B6B7;
   localparam logic [63:0] F_C      = 64'h0123456789ABCDEF;

   assign req_flit = {flit1, flit0};

   always #5 clk = ~clk;

   uart_tx_scheduler #(.NUM_REQ(2), .FLIT_WIDTH(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_flit  (req_flit),
      .req_ready (req_ready),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .grant_id  (grant_id)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] byte_of(input logic [63:0] f, input int k);
      logic [63:0] t;
      t = f << (8 * k);
      return t[63:56];
   endfunction

   // Leaves the bench at posedge+1 of the first cycle out of reset.
   task automatic do_reset();
      rst       = 1'b1;
      req_valid = 2'b00;
      tx_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Entered at posedge+1 of the first SEND cycle; returns at the negedge of the
   // cycle in which byte nbytes-1 is offered with tx_ready high.
   task automatic expect_flit(input string tag, input logic [63:0] f, input int id,
                              input bit bp, input int nbytes);
      int k = 0;
      int c = 0;
      while (k < nbytes && c < 40) begin
         tx_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
         @(negedge clk);
         chk({tag, "_valid"}, 64'(tx_valid), 64'(1'b1));
         chk({tag, "_data"},  64'(tx_data),  64'(byte_of(f, k)));
         chk({tag, "_busy"},  64'(busy),     64'(1'b1));
         chk({tag, "_gid"},   64'(grant_id), 64'(id));
         chk({tag, "_rdy"},   64'(req_ready), 64'(2'b00));
         if (tx_ready) k++;
         c++;
         if (k < nbytes) begin
            @(posedge clk);
            #1;
         end
      end
      chk({tag, "_count"}, 64'(k), 64'(nbytes));
      tx_ready = 1'b1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      flit0 = '0;
      flit1 = '0;

      // Reset state
      do_reset();
      @(negedge clk);
      chk("rst_valid", 64'(tx_valid),  64'(1'b0));
      chk("rst_busy",  64'(busy),      64'(1'b0));
      chk("rst_data",  64'(tx_data),   64'(8'h00));
      chk("rst_gid",   64'(grant_id),  64'(1'b0));
      chk("rst_rdy",   64'(req_ready), 64'(2'b00));

      // Single source, no backpressure
      @(posedge clk); #1;
      flit0 = F_SINGLE;
      req_valid = 2'b01;
      @(negedge clk);
      chk("s1_grant", 64'(req_ready), 64'(2'b01));
      chk("s1_pre_valid", 64'(tx_valid), 64'(1'b0));
      @(posedge clk); #1;
      req_valid = 2'b00;
      expect_flit("s1", F_SINGLE, 0, 1'b0, 8);
      @(posedge clk); #1;
      @(negedge clk);
      chk("s1_end_busy",  64'(busy),     64'(1'b0));
      chk("s1_end_valid", 64'(tx_valid), 64'(1'b0));
      chk("s1_end_gid",   64'(grant_id), 64'(1'b0));

      // Backpressure 1,0,0,1,... on the same flit
      @(posedge clk); #1;
      req_valid = 2'b01;
      @(negedge clk);
      chk("bp_grant", 64'(req_ready), 64'(2'b01));
      @(posedge clk); #1;
      req_valid = 2'b00;
      expect_flit("bp", F_SINGLE, 0, 1'b1, 8);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_end_valid", 64'(tx_valid), 64'(1'b0));

      // Round robin with both sources always valid
      do_reset();
      flit0 = F_A;
      flit1 = F_B;
      req_valid = 2'b11;
      for (int g = 0; g < 4; g++) begin
         @(negedge clk);
         chk($sformatf("rr%0d_grant", g), 64'(req_ready), (g % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
         chk($sformatf("rr%0d_idle", g), 64'(tx_valid), 64'(1'b0));
         @(posedge clk); #1;
         if (g == 3) req_valid = 2'b00;
         expect_flit($sformatf("rr%0d", g), (g % 2 == 0) ? F_A : F_B, g % 2, 1'b0, 8);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("rr_end_rdy", 64'(req_ready), 64'(2'b00));

      // Flit stability after acceptance
      @(posedge clk); #1;
      flit0 = F_C;
      req_valid = 2'b01;
      @(negedge clk);
      chk("st_grant", 64'(req_ready), 64'(2'b01));
      @(posedge clk); #1;
      req_valid = 2'b00;
      flit0 = 64'hFFFF_FFFF_FFFF_FFFF;
      expect_flit("st", F_C, 0, 1'b0, 8);
      @(posedge clk); #1;

      // Reset in the middle of source 1's flit
      do_reset();
      flit0 = F_A;
      flit1 = F_B;
      req_valid = 2'b11;
      @(negedge clk);
      chk("rm_grant0", 64'(req_ready), 64'(2'b01));
      @(posedge clk); #1;
      expect_flit("rm_a", F_A, 0, 1'b0, 8);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rm_grant1", 64'(req_ready), 64'(2'b10));
      @(posedge clk); #1;
      expect_flit("rm_b", F_B, 1, 1'b0, 3);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rm_valid", 64'(tx_valid),  64'(1'b0));
      chk("rm_busy",  64'(busy),      64'(1'b0));
      chk("rm_gid",   64'(grant_id),  64'(1'b0));
      chk("rm_rdy",   64'(req_ready), 64'(2'b01));
      @(posedge clk); #1;
      req_valid = 2'b00;
      expect_flit("rm_a2", F_A, 0, 1'b0, 8);
      @(posedge clk); #1;

      // No requests
      do_reset();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("nr_rdy",   64'(req_ready), 64'(2'b00));
         chk("nr_valid", 64'(tx_valid),  64'(1'b0));
         chk("nr_busy",  64'(busy),      64'(1'b0));
         @(posedge clk); #1;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
